data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder end of the data-memory load/store interface driven by the pipeline memory stage.
- Byte-addressed RAM with configurable access latency.
- Returns load data right-justified, so the requested byte or half sits at bit 0.
- Commits each store exactly once, and holds its done flags for as long as the initiator holds an unchanged request, so the stage can stall downstream without losing the result.

Parameters:
- DEPTH_BYTES, 4096: RAM size in bytes; power of two, at least 4.
- LATENCY, 1: cycles from a request first being sampled to its done flag rising; at least 1.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; fixed at 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- write_addr  in  ADDR_WIDTH  byte address of the store.
- write_data  in  32  store data; byte 0 is bits [7:0].
- write_activate  in  1  level; store request is valid.
- bytes_to_write  in  3  store size in bytes: 1, 2 or 4.
- write_done  out  1  store committed; held while the request is unchanged.
- fetch_addr  in  ADDR_WIDTH  byte address of the load.
- fetch_activate  in  1  level; load request is valid.
- fetched_data  out  32  bytes addr..addr+3, with the byte at addr in [7:0].
- fetch_done  out  1  fetched_data is valid; held while the request is unchanged.

Behaviour:
- Reset:
  - Asynchronous; asserting rst_n low at any time, including mid-access, forces state IDLE, write_done=0, fetch_done=0, fetched_data=0.
  - An access interrupted by reset has no effect: a store not yet committed is never committed.
  - RAM contents are not reset.
- Request definition:
  - Store: write_activate=1, request tuple {write_addr, write_data, bytes_to_write}.
  - Load: write_activate=0 and fetch_activate=1, request tuple {fetch_addr}.
  - Write has priority if both activates are high; fetch_done stays 0 in that case.
- Address decoding: only addr[log2(DEPTH_BYTES)-1:0] is used, and byte indices wrap modulo DEPTH_BYTES.
- State machine: IDLE, BUSY, DONE. Registers hold the latched request and its kind, plus a countdown counter.
  - IDLE or DONE, request present, and it differs from the latched request (or the state is IDLE): latch the request. If LATENCY=1, perform the access and go to DONE; otherwise load count=LATENCY-1 and go to BUSY.
  - BUSY: decrement the counter each edge. When count reaches 1, perform the access and go to DONE.
  - BUSY, request dropped or changed: abandon the access with no commit. Go to IDLE, or restart with the new request.
  - DONE, no request present: go to IDLE.
- Performing an access:
  - Store: write bytes_to_write bytes, write_data byte i to address (addr+i). A value of 0 writes nothing; values above 4 are treated as 4.
  - Load: register bytes addr..addr+3 into fetched_data.
  - All of this happens on a single edge. A store is never re-committed while it stays latched.
- Done outputs:
  - write_done = (state==DONE) && latched kind is store && the current request equals the latched tuple.
  - fetch_done is the same, for the load kind.
  - Both are combinational on the compare, so a new request that appears after an edge never observes the previous done.
- Back-to-back throughput: a changed request is restarted on the next edge, so done falls for at least one cycle between distinct accesses. Issuing the identical request twice is indistinguishable from holding it, which is safe because repeated loads and stores are idempotent.
- Read-after-write: a load that follows a store sees the committed data.
- fetched_data holds its value until the next load is performed.

Optional Feature:
- Macro: DATA_MEMORY_BOUNDS_CHECK_EN.
- When defined:
  - Adds output port access_fault (1 bit), equal to done && the latched address is >= DEPTH_BYTES (any address bit above the index is set, or addr+size-1 is past the end).
  - A faulting store writes nothing; a faulting load returns 0.
  - Done still asserts normally; access_fault resets to 0.
- When undefined: no port; addresses are truncated and wrap as described above.

Test Plan:
- Store, LATENCY=1: write_addr=0x10, data=0xAABBCCDD, size 4, held 3 cycles -> write_done=1 from cycle 1 while held; a following load of 0x10 returns 0xAABBCCDD.
- Byte/half placement: store 0x80 at 0x21 with size 1, then load 0x21 -> fetched_data[7:0]=0x80. Load 0x20 -> bits [15:8]=0x80 and the other bytes unchanged.
- Back-to-back change: load 0x10 done, then fetch_addr changes to 0x14 with activate held -> fetch_done=0 in the change cycle, then 1 with the new data one cycle later.
- LATENCY=3: store then drop the activate after 1 cycle -> no write_done and RAM unchanged. Reissue and hold -> write_done rises on the 3rd cycle.
- Reset mid-BUSY (LATENCY=4, rst_n low at cycle 2) -> done outputs and fetched_data go to 0 immediately; the store is not committed.
- With DATA_MEMORY_BOUNDS_CHECK_EN and DEPTH_BYTES=4096: load 0x1000 -> fetch_done=1, access_fault=1, fetched_data=0.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Load/store bus between the pipeline memory stage (master) and the data memory (slave).
// Carries access_fault only when DATA_MEMORY_BOUNDS_CHECK_EN is defined.
interface data_memory_responder_if #(
   parameter int ADDR_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0] write_addr;
   logic [31:0]           write_data;
   logic                  write_activate;
   logic [2:0]            bytes_to_write;
   logic                  write_done;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic                  fetch_activate;
   logic [31:0]           fetched_data;
   logic                  fetch_done;
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
   logic                  access_fault;
`endif

   modport master (
      output write_addr, write_data, write_activate, bytes_to_write,
      output fetch_addr, fetch_activate,
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
      input  access_fault,
`endif
      input  write_done, fetched_data, fetch_done
   );

   modport slave (
      input  write_addr, write_data, write_activate, bytes_to_write,
      input  fetch_addr, fetch_activate,
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
      output access_fault,
`endif
      output write_done, fetched_data, fetch_done
   );

endinterface

// File: rtl/data_memory_responder.sv
// Byte-addressed data RAM answering the memory stage with LATENCY-cycle loads/stores.
// Optional out-of-range fault reporting is enabled by defining DATA_MEMORY_BOUNDS_CHECK_EN.
module data_memory_responder #(
   parameter int DEPTH_BYTES = 4096,
   parameter int LATENCY     = 1,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
) (
   input logic                    clk,
   input logic                    rst_n,
   data_memory_responder_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH_BYTES);
   localparam int ROWS  = DEPTH_BYTES / 4;
   localparam int ROW_W = (IDX_W > 2) ? IDX_W - 2 : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {REQ_NONE, REQ_STORE, REQ_LOAD} kind_t;

   state_t                state, state_next;
   logic [CNT_W-1:0]      count, count_next;
   logic                  latch_en;
   logic                  do_access;

   kind_t                 cur_kind;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_WIDTH-1:0] cur_data;
   logic [2:0]            cur_size;
   logic [2:0]            size_eff;
   logic [IDX_W-1:0]      cur_idx;
   logic [1:0]            a_lo;
   logic                  cur_fault;

   kind_t                 lat_kind;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_data;
   logic [2:0]            lat_size;
   logic                  req_match;
   logic                  hold;

   logic [3:0][7:0]       rd_byte;
   logic [DATA_WIDTH-1:0] load_word;
   logic [DATA_WIDTH-1:0] fetched_q;

   // Loads carry zero data/size so one tuple compare serves both request kinds.
   // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      cur_kind = REQ_NONE;
      cur_addr = bus.fetch_addr;
      cur_data = '0;
      cur_size = '0;
      if (bus.write_activate) begin
         cur_kind = REQ_STORE;
         cur_addr = bus.write_addr;
         cur_data = bus.write_data;
         cur_size = bus.bytes_to_write;
      end else if (bus.fetch_activate) begin
         cur_kind = REQ_LOAD;
      end
   end

   assign size_eff  = (cur_size > 3'd4) ? 3'd4 : cur_size;
   assign cur_idx   = cur_addr[IDX_W-1:0];
   assign a_lo      = cur_idx[1:0];
   assign req_match = (cur_kind == lat_kind) && (cur_addr == lat_addr) &&
                      (cur_data == lat_data) && (cur_size == lat_size);

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      latch_en   = 1'b0;
      do_access  = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (cur_kind == REQ_NONE) begin
               state_next = IDLE;
            end else if (state == IDLE || !req_match) begin
               latch_en = 1'b1;
               if (LATENCY == 1) begin
                  do_access  = 1'b1;
                  state_next = DONE;
               end else begin
                  count_next = CNT_W'(LATENCY - 1);
                  state_next = BUSY;
               end
            end
         end
         BUSY: begin
            if (cur_kind == REQ_NONE) begin
               state_next = IDLE;
            end else if (!req_match) begin
               // A changed request abandons the pending access and starts over.
               latch_en   = 1'b1;
               count_next = CNT_W'(LATENCY - 1);
            end else if (count == CNT_W'(1)) begin
               do_access  = 1'b1;
               state_next = DONE;
            end else begin
               count_next = count - CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_kind <= REQ_NONE;
         lat_addr <= '0;
         lat_data <= '0;
         lat_size <= '0;
      end else if (latch_en) begin
         lat_kind <= cur_kind;
         lat_addr <= cur_addr;
         lat_data <= cur_data;
         lat_size <= cur_size;
      end
   end

   // Done is a live compare, so a new tuple never sees the previous access's flag.
   always_comb begin
      hold           = (state == DONE) && req_match;
      bus.write_done = hold && (lat_kind == REQ_STORE);
      bus.fetch_done = hold && (lat_kind == REQ_LOAD);
   end

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
   logic [ADDR_WIDTH:0] cur_last;
   logic [2:0]          span;
   logic                lat_fault;

   always_comb begin
      span      = (cur_kind == REQ_LOAD) ? 3'd4 : ((size_eff == 3'd0) ? 3'd1 : size_eff);
      cur_last  = {1'b0, cur_addr} + (ADDR_WIDTH+1)'(span) - (ADDR_WIDTH+1)'(1);
      cur_fault = (cur_last >= (ADDR_WIDTH+1)'(DEPTH_BYTES));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        lat_fault <= 1'b0;
      else if (latch_en) lat_fault <= cur_fault;
   end

   assign bus.access_fault = (bus.write_done || bus.fetch_done) && lat_fault;
`else
   assign cur_fault = 1'b0;
`endif

   // Four byte banks interleaved on addr[1:0]: each access touches every bank at most once.
   for (genvar k = 0; k < 4; k++) begin : g_bank
      logic [7:0]       mem [ROWS];
      logic [1:0]       off;
      logic [IDX_W-1:0] baddr;
      logic [ROW_W-1:0] row;
      logic             we;

      assign off   = 2'(k) - a_lo;
      assign baddr = cur_idx + IDX_W'(off);
      assign row   = ROW_W'(baddr >> 2);
      assign we    = do_access && (cur_kind == REQ_STORE) && ({1'b0, off} < size_eff) && !cur_fault;

      // NOTE: RAM storage has no reset; contents survive rst_n and only the control path is cleared.
      always_ff @(posedge clk) begin
         if (we) mem[row] <= cur_data[{off, 3'b000} +: 8];
      end

      assign rd_byte[k] = mem[row];
   end

   always_comb begin
      load_word = '0;
      for (int i = 0; i < 4; i++) begin
         load_word[8*i +: 8] = rd_byte[2'(a_lo + 2'(i))];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_q <= '0;
      end else if (do_access && (cur_kind == REQ_LOAD)) begin
         fetched_q <= cur_fault ? '0 : load_word;
      end
   end

   assign bus.fetched_data = fetched_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder at LATENCY 1, 3 and 4 with hand-computed expectations.
// Bounds-fault cases are exercised when DATA_MEMORY_BOUNDS_CHECK_EN is defined.
module tb_data_memory_responder;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   data_memory_responder_if #(.ADDR_WIDTH(32)) bus1 ();
   data_memory_responder_if #(.ADDR_WIDTH(32)) bus3 ();
   data_memory_responder_if #(.ADDR_WIDTH(32)) bus4 ();

   data_memory_responder #(.DEPTH_BYTES(4096), .LATENCY(1), .ADDR_WIDTH(32), .DATA_WIDTH(32))
      u_l1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   data_memory_responder #(.DEPTH_BYTES(4096), .LATENCY(3), .ADDR_WIDTH(32), .DATA_WIDTH(32))
      u_l3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
   data_memory_responder #(.DEPTH_BYTES(4096), .LATENCY(4), .ADDR_WIDTH(32), .DATA_WIDTH(32))
      u_l4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int u, input logic w, input logic f, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] s);
      case (u)
         1: begin
            bus1.write_activate = w; bus1.fetch_activate = f; bus1.write_addr = a;
            bus1.fetch_addr = a; bus1.write_data = d; bus1.bytes_to_write = s;
         end
         3: begin
            bus3.write_activate = w; bus3.fetch_activate = f; bus3.write_addr = a;
            bus3.fetch_addr = a; bus3.write_data = d; bus3.bytes_to_write = s;
         end
         default: begin
            bus4.write_activate = w; bus4.fetch_activate = f; bus4.write_addr = a;
            bus4.fetch_addr = a; bus4.write_data = d; bus4.bytes_to_write = s;
         end
      endcase
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      drive(1, 0, 0, 0, 0, 0);
      drive(3, 0, 0, 0, 0, 0);
      drive(4, 0, 0, 0, 0, 0);
      #12;
      check("rst_wd1", {31'b0, bus1.write_done}, 0);
      check("rst_fd1", {31'b0, bus1.fetch_done}, 0);
      check("rst_data1", bus1.fetched_data, 0);
      check("rst_data4", bus4.fetched_data, 0);
      rst_n = 1'b1;
      tick();

      // Full-word store held three cycles, then read back
      drive(1, 1, 0, 32'h10, 32'hAABBCCDD, 4); #1;
      check("st_pre", {31'b0, bus1.write_done}, 0);
      tick(); check("st_c1", {31'b0, bus1.write_done}, 1);
      tick(); check("st_c2", {31'b0, bus1.write_done}, 1);
      tick(); check("st_c3", {31'b0, bus1.write_done}, 1);
      drive(1, 0, 1, 32'h10, 0, 0); #1;
      check("ld_pre_wd", {31'b0, bus1.write_done}, 0);
      check("ld_pre_fd", {31'b0, bus1.fetch_done}, 0);
      tick();
      check("ld_fd", {31'b0, bus1.fetch_done}, 1);
      check("ld_data", bus1.fetched_data, 32'hAABBCCDD);

      // Back-to-back load change: done drops for the change cycle
      drive(1, 1, 0, 32'h14, 32'h12345678, 4); tick();
      check("st14_wd", {31'b0, bus1.write_done}, 1);
      drive(1, 0, 1, 32'h10, 0, 0); tick();
      check("b2b_fd0", {31'b0, bus1.fetch_done}, 1);
      bus1.fetch_addr = 32'h14; #1;
      check("b2b_gap", {31'b0, bus1.fetch_done}, 0);
      check("b2b_hold", bus1.fetched_data, 32'hAABBCCDD);
      tick();
      check("b2b_fd1", {31'b0, bus1.fetch_done}, 1);
      check("b2b_data", bus1.fetched_data, 32'h12345678);

      // Write priority and byte/half placement
      drive(1, 1, 1, 32'h20, 32'h44332211, 4); #1;
      check("prio_fd_pre", {31'b0, bus1.fetch_done}, 0);
      tick();
      check("prio_wd", {31'b0, bus1.write_done}, 1);
      check("prio_fd", {31'b0, bus1.fetch_done}, 0);
      drive(1, 1, 0, 32'h21, 32'h00000080, 1); #1;
      check("byte_gap", {31'b0, bus1.write_done}, 0);
      tick(); check("byte_wd", {31'b0, bus1.write_done}, 1);
      drive(1, 0, 1, 32'h21, 0, 0); tick();
      check("byte_ld21", {8'h00, bus1.fetched_data[23:0]}, 32'h00443380);
      drive(1, 0, 1, 32'h20, 0, 0); tick();
      check("byte_ld20", bus1.fetched_data, 32'h44338011);
      drive(1, 1, 0, 32'h22, 32'h0000BEEF, 2); tick();
      drive(1, 0, 1, 32'h20, 0, 0); tick();
      check("half_ld20", bus1.fetched_data, 32'hBEEF8011);
      drive(1, 1, 0, 32'h20, 32'hFFFFFFFF, 0); tick();
      check("size0_wd", {31'b0, bus1.write_done}, 1);
      drive(1, 0, 1, 32'h20, 0, 0); tick();
      check("size0_ld", bus1.fetched_data, 32'hBEEF8011);
      drive(1, 1, 0, 32'h30, 32'h0BADF00D, 7); tick();
      drive(1, 0, 1, 32'h30, 0, 0); tick();
      check("size7_ld", bus1.fetched_data, 32'h0BADF00D);

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
      drive(1, 0, 1, 32'h1000, 0, 0); tick();
      check("oob_fd", {31'b0, bus1.fetch_done}, 1);
      check("oob_fault", {31'b0, bus1.access_fault}, 1);
      check("oob_data", bus1.fetched_data, 0);
      drive(1, 0, 1, 32'h10, 0, 0); tick();
      check("inb_fault", {31'b0, bus1.access_fault}, 0);
      check("inb_data", bus1.fetched_data, 32'hAABBCCDD);
      drive(1, 1, 0, 32'hFFE, 32'h11223344, 4); tick();
      check("oob_st_wd", {31'b0, bus1.write_done}, 1);
      check("oob_st_fault", {31'b0, bus1.access_fault}, 1);
`else
      // Wrap-around at the top of the RAM and address aliasing
      drive(1, 1, 0, 32'h0, 32'h00000000, 4); tick();
      drive(1, 1, 0, 32'hFFE, 32'h11223344, 4); tick();
      check("wrap_wd", {31'b0, bus1.write_done}, 1);
      drive(1, 0, 1, 32'h0, 0, 0); tick();
      check("wrap_ld", bus1.fetched_data, 32'h00001122);
      drive(1, 0, 1, 32'h1010, 0, 0); tick();
      check("alias_ld", bus1.fetched_data, 32'hAABBCCDD);
`endif
      drive(1, 0, 0, 0, 0, 0); tick();

      // LATENCY=3: done on the third cycle; an abandoned store leaves RAM untouched
      drive(3, 1, 0, 32'h40, 32'h01020304, 4); tick();
      check("l3_c1", {31'b0, bus3.write_done}, 0);
      tick(); check("l3_c2", {31'b0, bus3.write_done}, 0);
      tick(); check("l3_c3", {31'b0, bus3.write_done}, 1);
      drive(3, 0, 0, 0, 0, 0); tick();
      drive(3, 1, 0, 32'h40, 32'hCAFEF00D, 4); tick();
      drive(3, 0, 0, 0, 0, 0); #1;
      check("l3_drop_a", {31'b0, bus3.write_done}, 0);
      tick(); tick();
      check("l3_drop_b", {31'b0, bus3.write_done}, 0);
      drive(3, 0, 1, 32'h40, 0, 0); tick(); tick();
      check("l3_ld_c2", {31'b0, bus3.fetch_done}, 0);
      tick();
      check("l3_ld_c3", {31'b0, bus3.fetch_done}, 1);
      check("l3_ld_data", bus3.fetched_data, 32'h01020304);
      drive(3, 0, 0, 0, 0, 0);

      // LATENCY=4: reset in BUSY aborts the store and clears outputs at once
      drive(1, 0, 1, 32'h10, 0, 0); tick();
      check("l4_bus1_fd", {31'b0, bus1.fetch_done}, 1);
      drive(4, 1, 0, 32'h80, 32'h55AA55AA, 4); tick(); tick(); tick(); tick();
      check("l4_st_wd", {31'b0, bus4.write_done}, 1);
      drive(4, 0, 1, 32'h80, 0, 0); tick(); tick(); tick(); tick();
      check("l4_ld_fd", {31'b0, bus4.fetch_done}, 1);
      check("l4_ld_data", bus4.fetched_data, 32'h55AA55AA);
      drive(4, 1, 0, 32'h80, 32'hDEADBEEF, 4); tick(); tick();
      rst_n = 1'b0; #1;
      check("rstb_data4", bus4.fetched_data, 0);
      check("rstb_wd4", {31'b0, bus4.write_done}, 0);
      check("rstb_fd1", {31'b0, bus1.fetch_done}, 0);
      check("rstb_data1", bus1.fetched_data, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(4, 0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      tick();
      drive(4, 0, 1, 32'h80, 0, 0); tick(); tick(); tick(); tick();
      check("rstb_ld_fd", {31'b0, bus4.fetch_done}, 1);
      check("rstb_ld_data", bus4.fetched_data, 32'h55AA55AA);
      drive(4, 0, 0, 0, 0, 0); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
